// File: rtl/mem_stage_seq.sv
// -----------------------------------------------------------------------------
// mem_stage_seq
//
// Handshaked memory stage between execute and write-back. It owns the stack
// pointer and drives an external data memory through a req/ack port that may
// take any number of cycles to answer. Two-beat stack ops (PUSH2/POP2) move
// 2*DATA_W bits as two consecutive word accesses. Write-back control and the
// ALU result are captured with the op and presented with the result pulse.
//
// Handshake semantics (upstream and memory side):
//   - An op transfers on a rising edge where in_valid=1 and in_ready=1.
//     While in_ready=0 the stage ignores in_valid and upstream must hold.
//   - A memory beat completes on a rising edge where mem_req=1 and mem_ack=1.
//     mem_addr/mem_we/mem_wdata stay stable from the first req cycle until
//     that edge. mem_ack with mem_req=0 has no effect.
//   - out_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   CLK, Reset          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   op                  0 NONE, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH2,
//                       6 POP2, 7 reserved (behaves as NONE)
//   alu_addr            ALU result; zero-extended address for LOAD/STORE
//   wdata               store/push data (single-beat ops use the low word)
//   wb_in               write-back control, passed through
//   out_valid           one-cycle result pulse
//   out_rdata           read data (0 for non-reads), held between pulses
//   out_alu, out_wb     captured alu_addr / wb_in
//   sp                  committed stack pointer
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  memory port
//   dbg_state           current FSM state (IDLE=0, BEAT0=1, BEAT1=2)
// -----------------------------------------------------------------------------
module mem_stage_seq #(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 20,
    parameter int unsigned       WB_W    = 10,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   alu_addr,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic [WB_W-1:0]     wb_in,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0]   out_alu,
    output logic [WB_W-1:0]     out_wb,
    output logic [ADDR_W-1:0]   sp,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [1:0]          dbg_state
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;
    localparam logic [2:0] OP_PUSH2 = 3'd5;
    localparam logic [2:0] OP_POP2  = 3'd6;

    localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SP_TWO = ADDR_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Committed stack pointer and the value it takes when the op completes.
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] sp_pend_q, sp_pend_d;

    // Captured op attributes and per-beat address/data.
    logic              two_beat_q, two_beat_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [DATA_W-1:0] wd0_q, wd0_d;
    logic [DATA_W-1:0] wd1_q, wd1_d;

    // Beat-0 read data of a POP2, held until the second beat completes.
    logic [DATA_W-1:0] rd_lo_q, rd_lo_d;

    // Result registers.
    logic                out_valid_q, out_valid_d;
    logic [2*DATA_W-1:0] out_rdata_q, out_rdata_d;
    logic [DATA_W-1:0]   out_alu_q, out_alu_d;
    logic [WB_W-1:0]     out_wb_q, out_wb_d;

    // ------------------------------------------------------------------
    // Op decode against the committed SP. Only used while IDLE, when no
    // access is in flight, so sp_q is the SP the new op must see.
    // ------------------------------------------------------------------
    logic              dec_mem;
    logic              dec_two_beat;
    logic              dec_write;
    logic              dec_read;
    logic [ADDR_W-1:0] dec_addr0;
    logic [ADDR_W-1:0] dec_addr1;
    logic [DATA_W-1:0] dec_wd0;
    logic [DATA_W-1:0] dec_wd1;
    logic [ADDR_W-1:0] dec_sp_next;

    always_comb begin
        dec_mem      = 1'b0;
        dec_two_beat = 1'b0;
        dec_write    = 1'b0;
        dec_read     = 1'b0;
        dec_addr0    = sp_q;
        dec_addr1    = sp_q;
        dec_wd0      = wdata[DATA_W-1:0];
        dec_wd1      = wdata[DATA_W-1:0];
        dec_sp_next  = sp_q;
        unique case (op)
            OP_LOAD: begin
                dec_mem   = 1'b1;
                dec_read  = 1'b1;
                dec_addr0 = ADDR_W'(alu_addr);
            end
            OP_STORE: begin
                dec_mem   = 1'b1;
                dec_write = 1'b1;
                dec_addr0 = ADDR_W'(alu_addr);
            end
            OP_PUSH: begin
                dec_mem     = 1'b1;
                dec_write   = 1'b1;
                dec_addr0   = sp_q;
                dec_sp_next = sp_q - SP_ONE;
            end
            OP_POP: begin
                dec_mem     = 1'b1;
                dec_read    = 1'b1;
                dec_addr0   = sp_q + SP_ONE;
                dec_sp_next = sp_q + SP_ONE;
            end
            OP_PUSH2: begin
                // High word goes to the higher address so POP2 reassembles
                // the value in the same order.
                dec_mem      = 1'b1;
                dec_two_beat = 1'b1;
                dec_write    = 1'b1;
                dec_addr0    = sp_q;
                dec_addr1    = sp_q - SP_ONE;
                dec_wd0      = wdata[2*DATA_W-1:DATA_W];
                dec_wd1      = wdata[DATA_W-1:0];
                dec_sp_next  = sp_q - SP_TWO;
            end
            OP_POP2: begin
                dec_mem      = 1'b1;
                dec_two_beat = 1'b1;
                dec_read     = 1'b1;
                dec_addr0    = sp_q + SP_ONE;
                dec_addr1    = sp_q + SP_TWO;
                dec_sp_next  = sp_q + SP_TWO;
            end
            default: begin
                // OP_NONE and the reserved encoding pass straight through.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    logic accept;
    logic beat0_ack;
    logic final_ack;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign beat0_ack = mem_ack && (state_q == ST_BEAT0);
    assign final_ack = mem_ack && (((state_q == ST_BEAT0) && !two_beat_q) ||
                                   (state_q == ST_BEAT1));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && dec_mem) begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
                    state_d = two_beat_q ? ST_BEAT1 : ST_IDLE;
                end
            end
            ST_BEAT1: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        two_beat_d  = two_beat_q;
        write_d     = write_q;
        read_d      = read_q;
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        wd0_d       = wd0_q;
        wd1_d       = wd1_q;
        sp_pend_d   = sp_pend_q;
        rd_lo_d     = rd_lo_q;
        sp_d        = sp_q;
        out_valid_d = 1'b0;
        out_rdata_d = out_rdata_q;
        out_alu_d   = out_alu_q;
        out_wb_d    = out_wb_q;

        if (accept) begin
            two_beat_d = dec_two_beat;
            write_d    = dec_write;
            read_d     = dec_read;
            addr0_d    = dec_addr0;
            addr1_d    = dec_addr1;
            wd0_d      = dec_wd0;
            wd1_d      = dec_wd1;
            sp_pend_d  = dec_sp_next;
            out_alu_d  = alu_addr;
            out_wb_d   = wb_in;
            if (!dec_mem) begin
                out_valid_d = 1'b1;
                out_rdata_d = '0;
            end
        end

        if (beat0_ack) begin
            rd_lo_d = mem_rdata;
        end

        // SP and the visible result change together, only when the last
        // beat completes; a partial two-beat op never moves SP.
        if (final_ack) begin
            out_valid_d = 1'b1;
            sp_d        = sp_pend_q;
            if (!read_q) begin
                out_rdata_d = '0;
            end else if (two_beat_q) begin
                out_rdata_d = {mem_rdata, rd_lo_q};
            end else begin
                out_rdata_d = {{DATA_W{1'b0}}, mem_rdata};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            sp_q        <= SP_INIT;
            sp_pend_q   <= SP_INIT;
            two_beat_q  <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            wd0_q       <= '0;
            wd1_q       <= '0;
            rd_lo_q     <= '0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_alu_q   <= '0;
            out_wb_q    <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            sp_pend_q   <= sp_pend_d;
            two_beat_q  <= two_beat_d;
            write_q     <= write_d;
            read_q      <= read_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            wd0_q       <= wd0_d;
            wd1_q       <= wd1_d;
            rd_lo_q     <= rd_lo_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_alu_q   <= out_alu_d;
            out_wb_q    <= out_wb_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Memory-side signals come straight from the state and the
    // captured beat registers, so they stay stable until the ack edge.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = mem_req && write_q;
    assign mem_addr  = (state_q == ST_BEAT1) ? addr1_q : addr0_q;
    assign mem_wdata = (state_q == ST_BEAT1) ? wd1_q : wd0_q;

    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_alu   = out_alu_q;
    assign out_wb    = out_wb_q;
    assign sp        = sp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage_seq.sv
// -----------------------------------------------------------------------------
// Testbench for mem_stage_seq. Inputs are driven and outputs sampled on the
// falling clock edge. A word-addressed memory model (associative array) and a
// stack-pointer model compute the expected beat addresses, write data, read
// results and SP for every op from the op definitions.
// -----------------------------------------------------------------------------
module tb_mem_stage_seq;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int WW = 10;
    localparam logic [AW-1:0] SP_RST = 20'hFFFFF;

    logic          CLK;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [DW-1:0] alu_addr;
    logic [2*DW-1:0] wdata;
    logic [WW-1:0] wb_in;
    logic          out_valid;
    logic [2*DW-1:0] out_rdata;
    logic [DW-1:0] out_alu;
    logic [WW-1:0] out_wb;
    logic [AW-1:0] sp;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    dbg_state;

    int vectors;
    int miscompares;

    // Reference model state
    logic [DW-1:0] mem_m [logic [AW-1:0]];
    logic [AW-1:0] sp_m;

    mem_stage_seq #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .WB_W   (WW),
        .SP_INIT(SP_RST)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .alu_addr (alu_addr),
        .wdata    (wdata),
        .wb_in    (wb_in),
        .out_valid(out_valid),
        .out_rdata(out_rdata),
        .out_alu  (out_alu),
        .out_wb   (out_wb),
        .sp       (sp),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (vectors=%0d)", vectors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory contents the model has never seen get a random value that is
    // then remembered, so later reads of the same word must agree.
    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (!mem_m.exists(a)) mem_m[a] = DW'($urandom);
        return mem_m[a];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the stage idle; returns at the falling
    // edge of the result cycle, with in_valid low.
    task automatic run_op(input logic [2:0] o, input logic [DW-1:0] alu,
                          input logic [2*DW-1:0] wd, input logic [WW-1:0] wb,
                          input int lat0, input int lat1);
        int              nb;
        int              lat;
        logic            we;
        logic [AW-1:0]   a [2];
        logic [DW-1:0]   wv [2];
        logic [DW-1:0]   rv;
        logic [2*DW-1:0] exp_rd;
        logic [AW-1:0]   sp_new;
        logic [AW-1:0]   ea;

        nb = 0; we = 1'b0; exp_rd = '0; sp_new = sp_m;
        a[0] = '0; a[1] = '0; wv[0] = '0; wv[1] = '0;
        ea = {4'h0, alu};
        case (o)
            3'd1: begin nb = 1; a[0] = ea; end
            3'd2: begin nb = 1; we = 1'b1; a[0] = ea; wv[0] = wd[15:0]; end
            3'd3: begin nb = 1; we = 1'b1; a[0] = sp_m; wv[0] = wd[15:0]; sp_new = sp_m - 20'd1; end
            3'd4: begin nb = 1; a[0] = sp_m + 20'd1; sp_new = sp_m + 20'd1; end
            3'd5: begin
                nb = 2; we = 1'b1;
                a[0] = sp_m; a[1] = sp_m - 20'd1;
                wv[0] = wd[31:16]; wv[1] = wd[15:0];
                sp_new = sp_m - 20'd2;
            end
            3'd6: begin
                nb = 2;
                a[0] = sp_m + 20'd1; a[1] = sp_m + 20'd2;
                sp_new = sp_m + 20'd2;
            end
            default: nb = 0;
        endcase

        in_valid = 1'b1; op = o; alu_addr = alu; wdata = wd; wb_in = wb;
        check("in_ready_idle", in_ready, 1);
        @(posedge CLK); @(negedge CLK);
        in_valid = 1'b0;
        op = 3'($urandom); alu_addr = DW'($urandom); wdata = $urandom; wb_in = WW'($urandom);

        if (nb > 0) begin
            check("out_valid_low_busy", out_valid, 0);
            for (int b = 0; b < nb; b++) begin
                lat = (b == 0) ? lat0 : lat1;
                for (int w = 0; w <= lat; w++) begin
                    check("mem_req", mem_req, 1);
                    check("in_ready_busy", in_ready, 0);
                    check("mem_addr", mem_addr, a[b]);
                    check("mem_we", mem_we, we);
                    if (we) check("mem_wdata", mem_wdata, wv[b]);
                    check("sp_hold", sp, sp_m);
                    if (w == lat) begin
                        mem_ack = 1'b1;
                        if (we) begin
                            mem_m[a[b]] = wv[b];
                            mem_rdata = DW'($urandom);
                        end else begin
                            rv = mem_read(a[b]);
                            mem_rdata = rv;
                            if (b == 1) exp_rd[31:16] = rv;
                            else        exp_rd[15:0]  = rv;
                        end
                    end else begin
                        mem_ack = 1'b0;
                        mem_rdata = DW'($urandom);
                    end
                    @(posedge CLK); @(negedge CLK);
                    mem_ack = 1'b0;
                    mem_rdata = DW'($urandom);
                end
            end
        end

        sp_m = sp_new;
        check("out_valid", out_valid, 1);
        check("out_rdata", out_rdata, exp_rd);
        check("out_alu", out_alu, alu);
        check("out_wb", out_wb, wb);
        check("sp", sp, sp_m);
        check("in_ready_done", in_ready, 1);
        check("mem_req_done", mem_req, 0);
    endtask

    // Consecutive NONE/reserved ops with in_valid held high every cycle.
    task automatic run_none_burst(input int n);
        logic [DW-1:0] alu_h;
        logic [WW-1:0] wb_h;
        for (int i = 0; i < n; i++) begin
            alu_h = DW'($urandom);
            wb_h  = WW'($urandom);
            in_valid = 1'b1;
            op = (i % 2 == 1) ? 3'd7 : 3'd0;
            alu_addr = alu_h; wb_in = wb_h; wdata = $urandom;
            check("burst_in_ready", in_ready, 1);
            @(posedge CLK); @(negedge CLK);
            check("burst_out_valid", out_valid, 1);
            check("burst_out_wb", out_wb, wb_h);
            check("burst_out_alu", out_alu, alu_h);
            check("burst_out_rdata", out_rdata, 0);
            check("burst_sp", sp, sp_m);
        end
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2*DW-1:0] wd;

        vectors = 0; miscompares = 0;
        Reset = 1'b1; in_valid = 1'b0; op = '0; alu_addr = '0; wdata = '0;
        wb_in = '0; mem_rdata = '0; mem_ack = 1'b0;
        sp_m = SP_RST;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rdata", out_rdata, 0);
        check("rst_out_alu", out_alu, 0);
        check("rst_out_wb", out_wb, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_sp", sp, 20'hFFFFF);
        check("rst_in_ready", in_ready, 1);

        // PUSH with same-cycle ack
        run_op(3'd3, 16'h0011, 32'h0000_ABCD, 10'h155, 0, 0);
        check("push_mem_word", mem_m[20'hFFFFF], 16'hABCD);
        check("push_sp", sp, 20'hFFFFE);

        // PUSH2 with three-cycle latency on each beat
        run_op(3'd5, 16'h0022, 32'h1234_5678, 10'h0AA, 3, 3);
        check("push2_hi_word", mem_m[20'hFFFFE], 16'h1234);
        check("push2_lo_word", mem_m[20'hFFFFD], 16'h5678);
        check("push2_sp", sp, 20'hFFFFC);

        // POP2 reassembles the pushed value
        run_op(3'd6, 16'h0033, 32'h0, 10'h3FF, 1, 2);
        check("pop2_value", out_rdata, 32'h1234_5678);
        check("pop2_sp", sp, 20'hFFFFE);

        // LOAD followed back-to-back by pass-through ops
        mem_m[20'h000F0] = 16'hBEEF;
        run_op(3'd1, 16'h00F0, 32'h0, 10'h001, 2, 0);
        check("load_value", out_rdata, 32'h0000_BEEF);
        run_none_burst(4);

        // POP twice: second one reads address 0 and wraps SP
        run_op(3'd4, 16'h0044, 32'h0, 10'h002, 0, 0);
        check("pop_sp_top", sp, 20'hFFFFF);
        run_op(3'd4, 16'h0055, 32'h0, 10'h003, 1, 0);
        check("pop_sp_wrap", sp, 20'h00000);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), DW'($urandom), $urandom, WW'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_none_burst(3);

        // Reset during the second beat of a PUSH2
        wd = $urandom;
        in_valid = 1'b1; op = 3'd5; wdata = wd; alu_addr = DW'($urandom); wb_in = WW'($urandom);
        @(posedge CLK); @(negedge CLK);
        in_valid = 1'b0;
        check("rstmid_beat0_addr", mem_addr, sp_m);
        check("rstmid_beat0_wdata", mem_wdata, wd[31:16]);
        mem_ack = 1'b1;
        mem_m[sp_m] = wd[31:16];
        @(posedge CLK); @(negedge CLK);
        mem_ack = 1'b0;
        check("rstmid_beat1_req", mem_req, 1);
        check("rstmid_beat1_addr", mem_addr, sp_m - 20'd1);
        check("rstmid_sp_unchanged", sp, sp_m);
        Reset = 1'b1;
        @(posedge CLK); @(negedge CLK);
        Reset = 1'b0;
        sp_m = SP_RST;
        check("rstmid_mem_req", mem_req, 0);
        check("rstmid_sp", sp, SP_RST);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        mem_ack = 1'b1;
        @(posedge CLK); @(negedge CLK);
        mem_ack = 1'b0;
        check("spurious_ack_req", mem_req, 0);
        check("spurious_ack_valid", out_valid, 0);
        check("spurious_ack_sp", sp, SP_RST);
        check("spurious_ack_ready", in_ready, 1);

        // Normal operation after the mid-op reset
        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom_range(0, 7)), DW'($urandom), $urandom, WW'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_seq.md
Name: mem_stage_seq

Overview:
- Parametrised, handshaked successor to the single-cycle memory stage. Sits between execute and write-back.
- Owns the stack pointer and drives an external data memory through a req/ack port. Supports variable-latency memory and two-beat (2*DATA_W) stack ops such as PC/flags push/pop.
- Stalls upstream while an access is in flight and forwards write-back control alongside the result.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 20, memory address width; SP width.
- WB_W, 10, width of pass-through write-back control bundle.
- SP_INIT, 2**ADDR_W-1, SP value after reset.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  stage can accept an op this cycle.
- op  in  3  0 NONE, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH2, 6 POP2, 7 reserved (treated as NONE).
- alu_addr  in  DATA_W  ALU result; zero-extended to ADDR_W for LOAD/STORE.
- wdata  in  2*DATA_W  store/push data; single-beat ops use wdata[DATA_W-1:0].
- wb_in  in  WB_W  write-back control, passed through.
- out_valid  out  1  one-cycle result pulse.
- out_rdata  out  2*DATA_W  read data; 0 for non-reads.
- out_alu  out  DATA_W  captured alu_addr.
- out_wb  out  WB_W  captured wb_in.
- sp  out  ADDR_W  current committed SP.
- mem_req  out  1  memory request.
- mem_we  out  1  write when 1, read when 0.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  completes the current beat.

Behaviour:
- Clock and reset: one clock CLK; Reset is synchronous, active-high. On Reset: state=IDLE, sp=SP_INIT, out_valid=0, out_rdata=0, out_alu=0, out_wb=0, mem_req=0, mem_we=0. in_ready=1 from the first cycle after reset.
- States: IDLE, BEAT0, BEAT1. in_ready=1 only in IDLE.
- IDLE, handshake with op NONE/7: pass-through. Next cycle out_valid=1, out_alu/out_wb captured, out_rdata=0. Back-to-back throughput is 1 op/cycle.
- IDLE, handshake with a memory op: capture op, alu_addr, wdata, wb_in and compute beat addresses. Go to BEAT0; out_valid=0 next cycle.
- BEAT0/BEAT1: mem_req=1, with mem_addr, mem_we and mem_wdata stable until mem_ack. mem_ack may arrive in the same cycle as first assertion of req, or any number of cycles later.
  - On ack: two-beat ops go BEAT0 to BEAT1.
  - On the final ack: return to IDLE, out_valid=1 next cycle, SP commit at the same edge.
- mem_ack while mem_req=0 is ignored.
- Addressing (all arithmetic modulo 2**ADDR_W; wrap is silent):
  - LOAD/STORE: one beat at zext(alu_addr); SP unchanged.
  - PUSH: write wdata[DATA_W-1:0] at sp; sp -= 1.
  - POP: read at sp+1 into out_rdata low half; high half 0; sp += 1.
  - PUSH2: beat0 writes wdata high half at sp, beat1 writes low half at sp-1; sp -= 2.
  - POP2: beat0 reads sp+1 into low half, beat1 reads sp+2 into high half; sp += 2.
- Read data capture: each beat's read data is registered at its ack edge. out_rdata holds its value until the next out_valid.
- Partial ops: SP is never updated partially. A two-beat op updates SP only at the final ack.
- Reset mid-operation: the in-flight op is discarded, no out_valid, SP forced to SP_INIT. mem_req is low in the cycle after the reset edge. Writes already acked are not undone.
- in_valid while in_ready=0: ignored; upstream must hold.

Test Plan:
- Reset, then PUSH wdata=0x0000_ABCD, ack same cycle -> mem_we=1, mem_addr=0xFFFFF, mem_wdata=0xABCD; next cycle out_valid=1, sp=0xFFFFE.
- PUSH2 wdata=0x1234_5678 from sp=0xFFFFE, ack delayed 3 cycles per beat -> writes 0x1234@0xFFFFE then 0x5678@0xFFFFD; in_ready=0 throughout; sp=0xFFFFC after the final ack.
- POP2 from sp=0xFFFFC, memory returns 0x5678 then 0x1234 -> reads @0xFFFFD then @0xFFFFE; out_rdata=0x1234_5678, sp=0xFFFFE.
- LOAD alu_addr=0x00F0, mem_rdata=0xBEEF, followed by back-to-back NONE ops -> mem_addr=0x000F0; out_rdata=0x0000_BEEF; each NONE yields out_valid the next cycle with out_wb echoed.
- POP at sp=0xFFFFF -> mem_addr=0x00000, sp wraps to 0x00000.
- Reset asserted during BEAT1 of PUSH2 -> next cycle mem_req=0, sp=0xFFFFF, out_valid=0, in_ready=1; a spurious mem_ack afterwards is ignored.
